// File: rtl/osc_pkg.sv
// Shared types and default widths for the pulse oscillator.
package osc_pkg;

  localparam int unsigned PHASE_W_DEF = 32;
  localparam int unsigned AMP_W_DEF   = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RELEASE = 2'd2
  } osc_state_e;

endpackage

// File: rtl/phase_accumulator.sv
// Phase register with clear, step enable and carry-out of the next add.
module phase_accumulator #(
  parameter int unsigned PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               enable,
  input  logic [PHASE_W-1:0] incr,
  output logic [PHASE_W-1:0] phase,
  output logic               carry
);

  logic [PHASE_W-1:0] phase_q;
  logic [PHASE_W:0]   sum;

  assign sum   = {1'b0, phase_q} + {1'b0, incr};
  // Carry reflects the add that would happen on this edge, whether or not it is enabled.
  assign carry = sum[PHASE_W];
  assign phase = phase_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else if (clear) begin
      phase_q <= '0;
    end else if (enable) begin
      phase_q <= sum[PHASE_W-1:0];
    end
  end

endmodule

// File: rtl/pulse_oscillator.sv
// Gated pulse-wave oscillator with IDLE/RUN/RELEASE envelope.
// Optional hard-sync input enabled by defining PULSE_OSCILLATOR_SYNC_EN.
module pulse_oscillator
  import osc_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned AMP_W   = AMP_W_DEF
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     step_in,
  input  logic [PHASE_W-1:0]       phase_incr_in,
  input  logic [PHASE_W-1:0]       duty_in,
  input  logic                     gate_in,
`ifdef PULSE_OSCILLATOR_SYNC_EN
  input  logic                     sync_in,
`endif
  output logic signed [AMP_W-1:0]  amp_out,
  output logic                     wrap_out,
  output logic                     active_out
);

  localparam logic [AMP_W-1:0] AmpPos = {1'b0, {(AMP_W-1){1'b1}}};
  localparam logic [AMP_W-1:0] AmpNeg = {1'b1, {(AMP_W-1){1'b0}}};

  osc_state_e         state_q, state_d;
  logic [PHASE_W-1:0] incr_sh_q, duty_sh_q;
  logic [PHASE_W-1:0] phase;
  logic               carry;
  logic               wrap_q;
  logic               running;
  logic               acc_clear;
  logic               acc_en;
  logic               sync_ev;
  logic               wrap_ev;
  logic               reload;

  assign running = (state_q != ST_IDLE);
  assign acc_en  = running & step_in;

`ifdef PULSE_OSCILLATOR_SYNC_EN
  assign sync_ev = running & sync_in;
`else
  assign sync_ev = 1'b0;
`endif

  assign wrap_ev = (acc_en & carry) | sync_ev;

  always_comb begin
    state_d   = state_q;
    reload    = wrap_ev;
    acc_clear = sync_ev;
    unique case (state_q)
      ST_IDLE: begin
        acc_clear = 1'b1;
        if (gate_in) begin
          state_d = ST_RUN;
          reload  = 1'b1;
        end
      end
      ST_RUN: begin
        if (!gate_in) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        // A wrap ends the release regardless of gate; a zero increment would never wrap.
        if (wrap_ev || (incr_sh_q == '0)) begin
          state_d   = ST_IDLE;
          acc_clear = 1'b1;
        end else if (gate_in) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        acc_clear = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      incr_sh_q <= '0;
      duty_sh_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wrap_q  <= wrap_ev;
      if (reload) begin
        incr_sh_q <= phase_incr_in;
        duty_sh_q <= duty_in;
      end
    end
  end

  phase_accumulator #(
    .PHASE_W (PHASE_W)
  ) u_acc (
    .clk    (clk_in),
    .rst    (rst_in),
    .clear  (acc_clear),
    .enable (acc_en),
    .incr   (incr_sh_q),
    .phase  (phase),
    .carry  (carry)
  );

  always_comb begin
    amp_out = '0;
    if (running) begin
      amp_out = (phase < duty_sh_q) ? AmpPos : AmpNeg;
    end
  end

  assign wrap_out   = wrap_q;
  assign active_out = running;

endmodule

// File: doc/pulse_oscillator.md
PULSE_OSCILLATOR -- requirements
Module: pulse_oscillator

Interface
REQ-001 Parameter: PHASE_W, default 32, phase accumulator, increment and duty width in bits (>=4).
REQ-002 Parameter: AMP_W, default 8, signed output amplitude width in bits (>=2).
REQ-003 Port: clk_in  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst_in  input  1  reset, asynchronous, active-high.
REQ-005 Port: step_in  input  1  phase-step strobe (sample-rate enable).
REQ-006 Port: phase_incr_in  input  PHASE_W  unsigned phase increment per step.
REQ-007 Port: duty_in  input  PHASE_W  unsigned pulse-width threshold.
REQ-008 Port: gate_in  input  1  note gate, level-sensitive.
REQ-009 Port: amp_out  output  AMP_W  signed two's-complement pulse amplitude.
REQ-010 Port: wrap_out  output  1  one-cycle pulse per phase wrap.
REQ-011 Port: active_out  output  1  high whenever state is not IDLE.

Function
REQ-012 FSM states IDLE, RUN and RELEASE shall be implemented.
REQ-013 In IDLE: phase held at 0, amp_out = 0, active_out = 0; gate_in = 1 -> RUN next clock, phase = 0, incr/duty shadow registers loaded from inputs.
REQ-014 In RUN/RELEASE, on step_in: phase <= phase + incr_sh modulo 2^PHASE_W; a wrap is the carry-out of that add.
REQ-015 incr_sh and duty_sh shall reload from phase_incr_in/duty_in only at entry to RUN from IDLE and at each wrap (glitch-free period/width change).
REQ-016 In RUN/RELEASE: amp_out = +(2^(AMP_W-1)-1) when phase < duty_sh, else -2^(AMP_W-1); combinational from registered phase/duty_sh/state, zero added latency.
REQ-017 duty_sh = 0 -> amp_out constant negative full-scale; duty_sh = 2^PHASE_W-1 -> positive except the single phase value 2^PHASE_W-1.
REQ-018 wrap_out shall be asserted for exactly the one clock following the step that wrapped; never in IDLE.
REQ-019 RUN, gate_in = 0 -> RELEASE next clock; phase keeps advancing.
REQ-020 RELEASE, gate_in = 1 -> RUN next clock, no phase reset, no shadow reload.
REQ-021 RELEASE, wrap -> IDLE on that same clock edge (phase = 0); wrap_out still pulses; gate_in is ignored on the wrap edge.
REQ-022 RELEASE with incr_sh = 0 -> IDLE next clock (no hang).
REQ-023 step_in ignored in IDLE; phase_incr_in/duty_in changes outside reload points shall have no effect.

Reset
REQ-024 rst_in = 1 shall force state IDLE, phase 0, incr_sh 0, duty_sh 0, amp_out 0, wrap_out 0, active_out 0 immediately, regardless of clock, including mid-period.
REQ-025 After rst_in deasserts, operation shall begin at the first rising edge, with gate_in handled per REQ-013.

Configuration
REQ-026 Macro PULSE_OSCILLATOR_SYNC_EN shall add input port sync_in (1 bit, hard-sync).
REQ-027 With macro: sync_in = 1 in RUN/RELEASE sets phase to 0 on that clock, overriding step_in, reloads shadows, pulses wrap_out next clock, and counts as a wrap for REQ-021.
REQ-028 Without macro: no sync_in port, no sync logic; behaviour exactly REQ-001..025.

Structure
REQ-029 Package osc_pkg shall hold the FSM state enum typedef and the default PHASE_W/AMP_W constants.
REQ-030 Sub-module phase_accumulator (PHASE_W parameter; clear, enable, increment in; phase and carry out) shall implement the accumulator.

Verification
REQ-031 PHASE_W=8, AMP_W=8, incr=64, duty=128, gate=1, step every clock -> amp_out 127,127,-128,-128 repeating; wrap_out once per 4 steps.
REQ-032 Same setup, duty_in changed to 64 mid-period -> current period unchanged; from next wrap amp_out 127,-128,-128,-128.
REQ-033 gate_in dropped at phase 64 -> active_out stays 1 until wrap, then amp_out 0, active_out 0; gate re-raised before wrap -> continues, no phase reset.
REQ-034 rst_in asserted asynchronously between clock edges at phase 128 -> all outputs 0 before the next edge; restart begins at phase 0.
REQ-035 With PULSE_OSCILLATOR_SYNC_EN: sync_in pulse at phase 192 -> phase 0, amp_out 127 next clock, wrap_out pulse; in RELEASE -> IDLE.
REQ-036 incr=0 in RUN -> amp_out constant, no wrap_out; gate low -> IDLE within 2 clocks.
